hdmi_src_switch: RTL and testbench

Frame-aligned, glitch-free video source selector for the HDMI output path. It replaces the fixed two-way VGA/FT combinational mux with a parametrised N-channel switch. Every input is resynchronised through a register pipeline. A source change takes effect only at a vertical-sync leading edge, and the output is then muted for a programmable number of frames so the TMDS encoder and the sink never see a torn frame. A timeout forces the switch if the outgoing source has stopped producing vsync.

---
 rtl/hdmi_src_switch.sv | 187 ++++++++++++++++++
 tb/tb_hdmi_src_switch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_src_switch.sv
// hdmi_src_switch: frame-aligned N-channel video source selector.
// Each source is registered through PIPE stages; a source change is taken at
// the outgoing source's vsync leading edge (or on ARM timeout) and the output
// is then blanked for MUTE_FRAMES frames of the new source.
module hdmi_src_switch #(
    parameter int NCH         = 2,
    parameter int RGB_W       = 24,
    parameter int PIPE        = 2,
    parameter int MUTE_FRAMES = 2,
    parameter int VS_POL      = 1,
    parameter int TIMEOUT_W   = 20,
    localparam int SW         = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*(RGB_W+3)-1:0] src_data,
    input  logic [SW-1:0]          sel,
    output logic [RGB_W-1:0]       o_rgb,
    output logic                   o_hs,
    output logic                   o_vs,
    output logic                   o_de,
    output logic                   o_blank,
    output logic [SW-1:0]          active_sel,
    output logic                   switching
);

    localparam int CW = RGB_W + 3;
    localparam int MW = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam logic          VS_LVL = (VS_POL != 0);
    localparam logic [SW:0]   NCH_W  = (SW+1)'(NCH);
    localparam logic [MW:0]   MF_W   = (MW+1)'(MUTE_FRAMES);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ARM  = 2'd1,
        ST_MUTE = 2'd2
    } state_t;

    // State entered after reset and after every switch: skip MUTE when no blanking is wanted.
    localparam state_t ST_POST = (MUTE_FRAMES == 0) ? ST_RUN : ST_MUTE;

    logic [CW-1:0]        r_pipe [PIPE][NCH];
    logic [NCH-1:0]       r_vs_d;
    logic [NCH-1:0]       w_vs_last;
    logic [NCH-1:0]       w_vle;

    state_t               r_state,  w_state_nxt;
    logic [SW-1:0]        r_active, w_active_nxt;
    logic [SW-1:0]        r_target, w_target_nxt;
    logic [TIMEOUT_W-1:0] r_tmo,    w_tmo_nxt;
    logic [MW-1:0]        r_mcnt,   w_mcnt_nxt;

    logic [TIMEOUT_W-1:0] w_tmo_inc;
    logic [MW:0]          w_mcnt_inc;
    logic                 w_sel_ok;
    logic                 w_vle_act;
    logic                 w_mute;
    logic [CW-1:0]        w_ch;

    logic [RGB_W-1:0]     r_rgb;
    logic                 r_hs, r_vs, r_de;

    // Input resynchronisation pipeline, one register chain per channel.
    // NOTE: this array is a register pipeline, not a RAM, so every stage is
    // cleared on reset; a real memory would be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PIPE; s++)
                for (int c = 0; c < NCH; c++)
                    r_pipe[s][c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_pipe[0][c] <= src_data[c*CW +: CW];
                for (int s = 1; s < PIPE; s++)
                    r_pipe[s][c] <= r_pipe[s-1][c];
            end
        end
    end

    // Last-stage vsync per channel and its leading-edge detect against the history.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch can be inferred.
    always_comb begin
        w_vs_last = '0;
        w_vle     = '0;
        for (int c = 0; c < NCH; c++) begin
            w_vs_last[c] = r_pipe[PIPE-1][c][RGB_W];
            w_vle[c]     = (w_vs_last[c] == VS_LVL) && (r_vs_d[c] != VS_LVL);
        end
    end

    // Vsync history; cleared to 0 so an idle-level vs right after reset is not an edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_vs_d <= '0;
        else       r_vs_d <= w_vs_last;
    end

    assign w_sel_ok   = ({1'b0, sel} < NCH_W);
    assign w_vle_act  = w_vle[r_active];
    assign w_tmo_inc  = (r_tmo == '1) ? r_tmo : r_tmo + TIMEOUT_W'(1);
    assign w_mcnt_inc = {1'b0, r_mcnt} + (MW+1)'(1);

    // Switch FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_POST;
            r_active <= '0;
            r_target <= '0;
            r_tmo    <= '0;
            r_mcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_target <= w_target_nxt;
            r_tmo    <= w_tmo_nxt;
            r_mcnt   <= w_mcnt_nxt;
        end
    end

    // Switch FSM next-state: arm on a new request, commit on vle/timeout, then mute.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_target_nxt = r_target;
        w_tmo_nxt    = r_tmo;
        w_mcnt_nxt   = r_mcnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_sel_ok && (sel != r_active)) begin
                    w_target_nxt = sel;
                    w_tmo_nxt    = '0;
                    w_state_nxt  = ST_ARM;
                end
            end
            ST_ARM: begin
                w_tmo_nxt = w_tmo_inc;
                if (w_sel_ok)
                    w_target_nxt = sel;
                // Request withdrawn wins over a coincident edge: no switch at all.
                if (w_sel_ok && (sel == r_active)) begin
                    w_state_nxt = ST_RUN;
                end else if (w_vle_act || (w_tmo_inc == '1)) begin
                    // A same-cycle sel change is honoured as the target.
                    w_active_nxt = w_sel_ok ? sel : r_target;
                    w_mcnt_nxt   = '0;
                    w_state_nxt  = ST_POST;
                end
            end
            ST_MUTE: begin
                if (w_vle_act) begin
                    if (w_mcnt_inc == MF_W) w_state_nxt = ST_RUN;
                    else                    w_mcnt_nxt  = w_mcnt_inc[MW-1:0];
                end
            end
            default: w_state_nxt = ST_POST;
        endcase
    end

    assign w_ch   = r_pipe[PIPE-1][r_active];
    assign w_mute = (r_state == ST_MUTE);

    // Output register after the mux; blanking uses last cycle's mute flag and selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_de  <= 1'b0;
        end else begin
            r_rgb <= (w_mute || !w_ch[RGB_W+2]) ? '0 : w_ch[RGB_W-1:0];
            r_hs  <= w_ch[RGB_W+1];
            r_vs  <= w_ch[RGB_W];
            r_de  <= w_ch[RGB_W+2] & ~w_mute;
        end
    end

    assign o_rgb      = r_rgb;
    assign o_hs       = r_hs;
    assign o_vs       = r_vs;
    assign o_de       = r_de;
    assign o_blank    = ~r_de;
    assign active_sel = r_active;
    assign switching  = (r_state != ST_RUN);

endmodule

// File: tb/tb_hdmi_src_switch.sv
// Directed bench for hdmi_src_switch: 3 channels, PIPE=2, MUTE_FRAMES=2,
// active-high vsync, 4-bit ARM timeout (switch after 15 ARM cycles).
module tb_hdmi_src_switch;

    localparam int NCH   = 3;
    localparam int RGB_W = 24;
    localparam int PIPE  = 2;
    localparam int MF    = 2;
    localparam int TW    = 4;
    localparam int CW    = RGB_W + 3;
    localparam int SW    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH*CW-1:0]    src_data;
    logic [SW-1:0]        sel;
    logic [RGB_W-1:0]     o_rgb;
    logic                 o_hs, o_vs, o_de, o_blank;
    logic [SW-1:0]        active_sel;
    logic                 switching;

    logic [NCH-1:0]       ch_vs, ch_hs, ch_de;
    logic [RGB_W-1:0]     ch_rgb [NCH];

    int n_asserts = 0;
    int n_fail    = 0;

    hdmi_src_switch #(
        .NCH(NCH), .RGB_W(RGB_W), .PIPE(PIPE), .MUTE_FRAMES(MF),
        .VS_POL(1), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .sel(sel),
        .o_rgb(o_rgb), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_blank(o_blank),
        .active_sel(active_sel), .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++)
            src_data[c*CW +: CW] = {ch_de[c], ch_hs[c], ch_vs[c], ch_rgb[c]};
    endtask

    // Apply current inputs, advance one rising edge, settle 1 time unit.
    task automatic clk1();
        drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    // One-cycle vsync pulse on channel c; returns after the edge that captures it.
    task automatic pulse(input int c);
        ch_vs[c] = 1'b1;
        clk1();
        ch_vs[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sel   = '0;
        ch_vs = '0;
        ch_hs = '0;
        ch_de = 3'b111;
        ch_rgb[0] = 24'h123456;
        ch_rgb[1] = 24'h654321;
        ch_rgb[2] = 24'hAABBCC;
        drive();

        // ---- Reset state
        idle(3);
        check("rst_blank",  o_blank,    1);
        check("rst_de",     o_de,       0);
        check("rst_rgb",    o_rgb,      0);
        check("rst_active", active_sel, 0);
        check("rst_switch", switching,  1);

        // ---- Reset release: mute for two ch0 frames, then unmute
        reset = 1'b0;
        idle(4);
        check("s1_mute0", o_de, 0);
        pulse(0);
        idle(4);
        check("s1_mute1", o_de, 0);
        check("s1_sw1",   switching, 1);
        pulse(0);
        clk1();                                  // t: second vle at last stage
        check("s1_t_de",   o_de, 0);
        clk1();                                  // t+1
        check("s1_t1_de",  o_de, 0);
        check("s1_t1_vs",  o_vs, 1);
        check("s1_t1_rgb", o_rgb, 0);
        check("s1_t1_sw",  switching, 0);
        clk1();                                  // t+2
        check("s1_t2_de",    o_de, 1);
        check("s1_t2_rgb",   o_rgb, 24'h123456);
        check("s1_t2_blank", o_blank, 0);
        check("s1_t2_vs",    o_vs, 0);
        check("s1_active",   active_sel, 0);

        // ---- de=0 blanks rgb; latency PIPE+1
        ch_de[0] = 1'b0;
        idle(2);
        check("de0_lat_de", o_de, 1);
        clk1();
        check("de0_de",    o_de, 0);
        check("de0_rgb",   o_rgb, 0);
        check("de0_blank", o_blank, 1);
        ch_de[0] = 1'b1;
        ch_hs[0] = 1'b1;
        idle(3);
        check("hs_pass", o_hs, 1);
        check("hs_rgb",  o_rgb, 24'h123456);
        ch_hs[0] = 1'b0;
        idle(3);

        // ---- Mid-frame switch 0 -> 1
        sel = 2'd1;
        clk1();
        check("s2_arm_sw",  switching, 1);
        check("s2_arm_act", active_sel, 0);
        idle(3);
        check("s2_arm_rgb", o_rgb, 24'h123456);
        pulse(0);
        clk1();                                  // t
        check("s2_t_act", active_sel, 0);
        clk1();                                  // t+1: old edge sample
        check("s2_t1_act", active_sel, 1);
        check("s2_t1_vs",  o_vs, 1);
        check("s2_t1_rgb", o_rgb, 24'h123456);
        check("s2_t1_de",  o_de, 1);
        clk1();                                  // t+2: new source, muted
        check("s2_t2_de",  o_de, 0);
        check("s2_t2_rgb", o_rgb, 0);
        check("s2_t2_vs",  o_vs, 0);
        check("s2_t2_sw",  switching, 1);
        pulse(1);
        idle(4);
        check("s2_m1_de", o_de, 0);
        check("s2_m1_sw", switching, 1);
        pulse(1);
        clk1();
        clk1();
        check("s2_u1_de", o_de, 0);
        check("s2_u1_sw", switching, 0);
        clk1();
        check("s2_u2_de",  o_de, 1);
        check("s2_u2_rgb", o_rgb, 24'h654321);

        // ---- sel toggles away and back within a frame: no switch
        sel = 2'd0;
        clk1();
        check("s3_arm", switching, 1);
        sel = 2'd1;
        clk1();
        check("s3_back_sw",  switching, 0);
        check("s3_back_act", active_sel, 1);
        // Return to active_sel on the same cycle as the old source's vle
        sel = 2'd0;
        ch_vs[1] = 1'b1;
        clk1();
        check("s3b_arm", switching, 1);
        ch_vs[1] = 1'b0;
        clk1();                                  // t: vle of ch1
        sel = 2'd1;
        clk1();
        check("s3b_sw",  switching, 0);
        check("s3b_act", active_sel, 1);
        clk1();
        check("s3b_de",  o_de, 1);
        check("s3b_rgb", o_rgb, 24'h654321);

        // ---- Timeout: outgoing ch1 vs stalled, request ch0
        sel = 2'd0;
        clk1();
        check("s4_arm_sw", switching, 1);
        idle(14);
        check("s4_pre_act", active_sel, 1);
        clk1();
        check("s4_act", active_sel, 0);
        check("s4_sw",  switching, 1);
        clk1();
        check("s4_mute_de", o_de, 0);
        // Request made during MUTE is deferred; ch1 edges do not count
        sel = 2'd1;
        pulse(1);
        idle(3);
        check("s4_def_act", active_sel, 0);
        check("s4_def_sw",  switching, 1);
        check("s4_def_de",  o_de, 0);
        pulse(0);
        idle(4);
        check("s4_m1_de", o_de, 0);
        pulse(0);
        clk1();
        clk1();
        check("s4_u1_de",  o_de, 0);
        check("s4_u1_sw",  switching, 0);
        check("s4_u1_act", active_sel, 0);
        clk1();
        check("s4_u2_de",  o_de, 1);
        check("s4_u2_rgb", o_rgb, 24'h123456);
        check("s4_rearm",  switching, 1);
        sel = 2'd0;
        clk1();
        check("s4_cancel", switching, 0);

        // ---- Out-of-range sel ignored
        sel = 2'd3;
        idle(2);
        check("s5_sw",  switching, 0);
        check("s5_act", active_sel, 0);

        // ---- sel change on the vle cycle becomes the target
        sel = 2'd1;
        clk1();
        check("s5b_arm", switching, 1);
        pulse(0);
        clk1();                                  // t
        sel = 2'd2;
        clk1();
        check("s5b_act", active_sel, 2);
        ch_hs[2] = 1'b1;
        idle(3);
        check("s5b_de", o_de, 0);
        check("s5b_hs", o_hs, 1);

        // ---- Asynchronous reset mid-MUTE
        #2;
        reset = 1'b1;
        #1;
        check("r6_hs",    o_hs, 0);
        check("r6_act",   active_sel, 0);
        check("r6_blank", o_blank, 1);
        check("r6_sw",    switching, 1);
        ch_hs[2] = 1'b0;
        sel = 2'd0;
        idle(2);
        reset = 1'b0;
        idle(4);
        check("r6_mute0", o_de, 0);
        pulse(0);
        idle(4);
        check("r6_mute1", o_de, 0);
        pulse(0);
        clk1();
        clk1();
        check("r6_u1_de", o_de, 0);
        clk1();
        check("r6_u2_de",  o_de, 1);
        check("r6_u2_rgb", o_rgb, 24'h123456);
        check("r6_act0",   active_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
